// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered 4-bit grayscale frame store for a VGA scanout.
//
// The writer fills the back bank while the reader scans the front bank. A swap
// request is parked until the next rising edge of vga_reset_in (frame start),
// so a displayed frame never mixes the two banks.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   vga_next_pixel_in   rising edge advances the read pointer one pixel
//   vga_reset_in        level; holds the read pointer at frame start
//   vga_pixel_out       registered gray value of the current pixel
//   line_repeat_in      extra replays per stored line, latched during vga_reset_in
//   wr_en_in/addr/data  pixel write into the back bank
//   swap_req_in         request a front/back exchange
//   swap_pending_out    swap requested, not yet applied
//   front_bank_out      bank currently being displayed
module frame_buffer #(
  parameter int H_PIXELS   = 40,
  parameter int V_PIXELS   = 30,
  parameter int WIDTH_ADDR = $clog2(H_PIXELS*V_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vga_next_pixel_in,
  input  logic                  vga_reset_in,
  output logic [3:0]            vga_pixel_out,
  input  logic [1:0]            line_repeat_in,
  input  logic                  wr_en_in,
  input  logic [WIDTH_ADDR-1:0] wr_addr_in,
  input  logic [3:0]            wr_data_in,
  input  logic                  swap_req_in,
  output logic                  swap_pending_out,
  output logic                  front_bank_out
);

  localparam int N_PIX = H_PIXELS * V_PIXELS;
  localparam logic [WIDTH_ADDR-1:0] COL_LAST  = WIDTH_ADDR'(H_PIXELS - 1);
  localparam logic [WIDTH_ADDR-1:0] LINE_STEP = WIDTH_ADDR'(H_PIXELS);
  localparam logic [WIDTH_ADDR-1:0] BASE_LAST = WIDTH_ADDR'((V_PIXELS - 1) * H_PIXELS);
  localparam logic [WIDTH_ADDR:0]   N_PIX_W   = (WIDTH_ADDR + 1)'(N_PIX);

  logic [3:0] mem_q [2][N_PIX];

  logic                  next_q, next_d;
  logic                  vrst_q, vrst_d;
  logic [WIDTH_ADDR-1:0] col_q, col_d;
  logic [WIDTH_ADDR-1:0] base_q, base_d;
  logic [1:0]            rep_q, rep_d;
  logic [1:0]            repeat_q, repeat_d;
  logic                  front_q, front_d;
  logic                  pending_q, pending_d;
  logic [3:0]            pixel_q, pixel_d;

  logic                  adv;
  logic                  swap;
  logic                  wr_ok;
  logic [WIDTH_ADDR-1:0] rd_addr;

  assign wr_ok = wr_en_in && ({1'b0, wr_addr_in} < N_PIX_W);

  // The write bank is chosen from the pre-swap front index, so a write in the
  // swap cycle lands in the bank that is about to become visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[~front_q][wr_addr_in] <= wr_data_in;
  end

  always_comb begin
    next_d    = vga_next_pixel_in;
    vrst_d    = vga_reset_in;
    col_d     = col_q;
    base_d    = base_q;
    rep_d     = rep_q;
    repeat_d  = repeat_q;
    front_d   = front_q;
    pending_d = pending_q;

    adv  = vga_next_pixel_in && !next_q && !vga_reset_in;
    swap = vga_reset_in && !vrst_q && (pending_q || swap_req_in);

    if (swap) begin
      front_d   = ~front_q;
      pending_d = 1'b0;
    end else if (swap_req_in) begin
      pending_d = 1'b1;
    end

    if (vga_reset_in) begin
      col_d    = '0;
      rep_d    = '0;
      base_d   = '0;
      repeat_d = line_repeat_in;
    end else if (adv) begin
      if (col_q < COL_LAST) begin
        col_d = col_q + 1'b1;
      end else begin
        col_d = '0;
        if (rep_q == repeat_q) begin
          rep_d  = '0;
          base_d = (base_q == BASE_LAST) ? '0 : base_q + LINE_STEP;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end

    // Look up with the just-updated pointer and bank so the output lags the
    // advance event by exactly one clock.
    rd_addr = base_d + col_d;
    pixel_d = mem_q[front_d][rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_q    <= 1'b0;
      vrst_q    <= 1'b0;
      col_q     <= '0;
      base_q    <= '0;
      rep_q     <= '0;
      repeat_q  <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      pixel_q   <= '0;
    end else begin
      next_q    <= next_d;
      vrst_q    <= vrst_d;
      col_q     <= col_d;
      base_q    <= base_d;
      rep_q     <= rep_d;
      repeat_q  <= repeat_d;
      front_q   <= front_d;
      pending_q <= pending_d;
      pixel_q   <= pixel_d;
    end
  end

  assign vga_pixel_out    = pixel_q;
  assign swap_pending_out = pending_q;
  assign front_bank_out   = front_q;

endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;

  localparam int H = 40;
  localparam int V = 30;
  localparam int N = H * V;
  localparam int WA = $clog2(N);

  logic          clk;
  logic          rst;
  logic          vga_next_pixel_in;
  logic          vga_reset_in;
  logic [3:0]    vga_pixel_out;
  logic [1:0]    line_repeat_in;
  logic          wr_en_in;
  logic [WA-1:0] wr_addr_in;
  logic [3:0]    wr_data_in;
  logic          swap_req_in;
  logic          swap_pending_out;
  logic          front_bank_out;

  frame_buffer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk              (clk),
    .rst              (rst),
    .vga_next_pixel_in(vga_next_pixel_in),
    .vga_reset_in     (vga_reset_in),
    .vga_pixel_out    (vga_pixel_out),
    .line_repeat_in   (line_repeat_in),
    .wr_en_in         (wr_en_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .swap_req_in      (swap_req_in),
    .swap_pending_out (swap_pending_out),
    .front_bank_out   (front_bank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_pix  = 0;

  // Reference model: pointer kept as (line number, column, replay count).
  int m_mem [2][N];
  int m_front, m_pend, m_pix;
  int m_line, m_col, m_rep, m_rpt;
  int m_prev_next, m_prev_rst;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int wbank;
    bit adv, rise;
    if (rst) begin
      m_front = 0; m_pend = 0; m_pix = 0;
      m_line = 0; m_col = 0; m_rep = 0; m_rpt = 0;
      m_prev_next = 0; m_prev_rst = 0;
      return;
    end
    wbank = 1 - m_front;
    adv  = vga_next_pixel_in && !m_prev_next && !vga_reset_in;
    rise = vga_reset_in && !m_prev_rst;
    if (rise && (m_pend || swap_req_in)) begin
      m_front = 1 - m_front;
      m_pend  = 0;
    end else if (swap_req_in) begin
      m_pend = 1;
    end
    if (vga_reset_in) begin
      m_line = 0; m_col = 0; m_rep = 0; m_rpt = int'(line_repeat_in);
    end else if (adv) begin
      if (m_col < H - 1) m_col++;
      else begin
        m_col = 0;
        if (m_rep == m_rpt) begin
          m_rep  = 0;
          m_line = (m_line + 1) % V;
        end else m_rep++;
      end
    end
    // Output sees memory as it was before this edge's write commits.
    m_pix = m_mem[m_front][m_line * H + m_col];
    if (wr_en_in && int'(wr_addr_in) < N) m_mem[wbank][int'(wr_addr_in)] = int'(wr_data_in);
    m_prev_next = vga_next_pixel_in;
    m_prev_rst  = vga_reset_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("front_bank", front_bank_out, m_front);
    check_val("swap_pending", swap_pending_out, m_pend);
    if (chk_pix) check_val("pixel", vga_pixel_out, m_pix);
  endtask

  task automatic advance();
    vga_next_pixel_in = 1'b1; tick();
    vga_next_pixel_in = 1'b0; tick();
  endtask

  task automatic frame_start();
    vga_reset_in = 1'b1; tick();
    vga_reset_in = 1'b0; tick();
  endtask

  task automatic fill_back(input bit ramp);
    for (int i = 0; i < N; i++) begin
      wr_en_in   = 1'b1;
      wr_addr_in = WA'(i);
      wr_data_in = ramp ? 4'(i % 16) : 4'($urandom_range(0, 15));
      tick();
    end
    wr_en_in = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) m_mem[b][i] = 0;
    rst = 1'b1; vga_next_pixel_in = 1'b0; vga_reset_in = 1'b0;
    line_repeat_in = 2'd0; wr_en_in = 1'b0; wr_addr_in = '0;
    wr_data_in = '0; swap_req_in = 1'b0;

    tick();
    check_val("reset_pixel", vga_pixel_out, 0);
    tick();
    rst = 1'b0;

    // Back bank ramp, swap at frame start, then five advances.
    fill_back(1'b1);
    swap_req_in = 1'b1; tick();
    swap_req_in = 1'b0;
    vga_reset_in = 1'b1; tick();
    chk_pix = 1;
    check_val("s1_front", front_bank_out, 1);
    check_val("s1_pending", swap_pending_out, 0);
    check_val("s1_pix0", vga_pixel_out, 0);
    vga_reset_in = 1'b0; tick();
    for (int k = 1; k <= 5; k++) begin
      vga_next_pixel_in = 1'b1; tick();
      check_val("s1_adv", vga_pixel_out, k);
      vga_next_pixel_in = 1'b0; tick();
    end

    fill_back(1'b0);

    // Line replay with repeat = 1.
    line_repeat_in = 2'd1;
    frame_start();
    line_repeat_in = 2'd0;
    for (int k = 0; k < 39; k++) advance();
    check_val("rep_adv39", vga_pixel_out, 7);
    advance();
    check_val("rep_adv40", vga_pixel_out, 0);
    for (int k = 0; k < 39; k++) advance();
    check_val("rep_adv79", vga_pixel_out, 7);
    advance();
    check_val("rep_adv80", vga_pixel_out, 8);

    // Whole-frame wrap with repeat = 0.
    frame_start();
    for (int k = 0; k < N - 1; k++) advance();
    check_val("wrap_last", vga_pixel_out, 15);
    advance();
    check_val("wrap_first", vga_pixel_out, 0);

    // Held-high advance input.
    frame_start();
    vga_next_pixel_in = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    vga_next_pixel_in = 1'b0; tick();
    check_val("hold_one_adv", vga_pixel_out, 1);
    vga_reset_in = 1'b1; tick();
    vga_next_pixel_in = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_val("hold_in_reset", vga_pixel_out, 0);
    vga_next_pixel_in = 1'b0; tick();
    vga_reset_in = 1'b0; tick();
    check_val("hold_after_reset", vga_pixel_out, 0);

    // Swap request and write coincide with the frame-start rise.
    vga_reset_in = 1'b1; swap_req_in = 1'b1;
    wr_en_in = 1'b1; wr_addr_in = '0; wr_data_in = 4'hF;
    tick();
    check_val("s5_front", front_bank_out, 0);
    check_val("s5_pending", swap_pending_out, 0);
    swap_req_in = 1'b0; wr_en_in = 1'b0;
    tick();
    check_val("s5_pix", vga_pixel_out, 15);
    vga_reset_in = 1'b0; tick();

    // Reset mid-line with a swap pending.
    swap_req_in = 1'b1; tick();
    swap_req_in = 1'b0;
    for (int k = 0; k < 17; k++) advance();
    check_val("s6_pending_set", swap_pending_out, 1);
    rst = 1'b1; wr_en_in = 1'b1; wr_addr_in = WA'(N); wr_data_in = 4'h5;
    tick();
    check_val("s6_rst_pix", vga_pixel_out, 0);
    check_val("s6_rst_pending", swap_pending_out, 0);
    rst = 1'b0; wr_en_in = 1'b0;
    tick();
    check_val("s6_restart_pix", vga_pixel_out, 15);
    frame_start();
    check_val("s6_no_swap", front_bank_out, 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) vga_reset_in = ~vga_reset_in;
      vga_next_pixel_in = 1'($urandom_range(0, 1));
      swap_req_in = ($urandom_range(0, 29) == 0);
      line_repeat_in = 2'($urandom_range(0, 3));
      wr_en_in = 1'($urandom_range(0, 1));
      wr_addr_in = WA'($urandom_range(0, N + 100));
      wr_data_in = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
